// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NREQ writers.
// Grants bursts of up to MAXBURST beats and stalls while the FIFO is full.
module fifo_push_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAXBURST = 4,
  parameter int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int unsigned CNTW     = $clog2(MAXBURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_d;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            owner_req;
  logic            beat;
  logic [WIDTH-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign owner_req = req[owner_q];
  assign beat      = (state_q == BURST) && owner_req && !fifo_full;
  assign busy_d    = (state_d == BURST);

  // First requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and push-port outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id;
    ack        = '0;
    fifo_push  = 1'b0;
    fifo_data  = '0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          state_d    = BURST;
          owner_d    = pick;
          grant_id_d = pick;
          cnt_d      = '0;
        end
      end
      BURST: begin
        if (beat) begin
          ack[owner_q] = 1'b1;
          fifo_push    = 1'b1;
          fifo_data    = words[owner_q];
          cnt_d        = cnt_q + CNTW'(1);
        end
        // Counter is cleared on exit so it never reaches MAXBURST
        if (!owner_req || (beat && cnt_q == CNTW'(MAXBURST - 1))) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rr_ptr_d = IDW'((32'(owner_q) + 32'd1) % NREQ);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: directed scenarios plus random
// writers, checked against a transaction-level round-robin reference model.
module tb_fifo_push_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAXBURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic [1:0]            grant_id;
  logic                  busy;

  logic [0:0]       req1;
  logic [WIDTH-1:0] req_data1;
  logic [0:0]       ack1;
  logic             full1;
  logic             push1;
  logic [WIDTH-1:0] data1;
  logic [0:0]       gid1;
  logic             busy1;

  fifo_push_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .grant_id(grant_id), .busy(busy)
  );

  fifo_push_arbiter #(.NREQ(1), .WIDTH(WIDTH), .MAXBURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .ack(ack1),
    .fifo_full(full1), .fifo_push(push1), .fifo_data(data1),
    .grant_id(gid1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: current and next-cycle arbitration state
  bit m_burst, nx_burst;
  int m_owner, m_ptr, m_cnt, m_gid;
  int nx_owner, nx_ptr, nx_cnt, nx_gid;
  bit exp_busy;
  int exp_gid;
  bit last_beat;
  int last_id;

  logic [WIDTH-1:0] wdata [NREQ];
  int               rem   [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_burst = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_gid = 0;
    nx_burst = 1'b0; nx_owner = 0; nx_ptr = 0; nx_cnt = 0; nx_gid = 0;
  endtask

  task automatic model_next(input logic [NREQ-1:0] r, input bit f, output bit beat);
    int p;
    beat = m_burst && r[m_owner] && !f;
    nx_burst = m_burst; nx_owner = m_owner; nx_ptr = m_ptr; nx_cnt = m_cnt; nx_gid = m_gid;
    if (!m_burst) begin
      p = rr_pick(r, m_ptr);
      if (p >= 0 && !f) begin
        nx_burst = 1'b1; nx_owner = p; nx_gid = p; nx_cnt = 0;
      end
    end else begin
      if (beat) nx_cnt = m_cnt + 1;
      if (!r[m_owner] || nx_cnt == MAXBURST) begin
        nx_burst = 1'b0; nx_cnt = 0; nx_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // mode 0: normal cycle, 1: reset held through the cycle, 2: reset pulse mid-cycle
  task automatic step(input logic [NREQ-1:0] r, input bit f, input int mode);
    bit beat;
    @(posedge clk);
    #1;
    m_burst = nx_burst; m_owner = nx_owner; m_ptr = nx_ptr; m_cnt = nx_cnt; m_gid = nx_gid;
    req       = r;
    fifo_full = f;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = wdata[i];
    last_beat = 1'b0;
    if (mode == 1) begin
      rst = 1'b0;
      model_reset();
      exp_busy = 1'b0;
      exp_gid  = 0;
      return;
    end
    rst      = 1'b1;
    exp_busy = m_burst;
    exp_gid  = m_gid;
    model_next(r, f, beat);
    if (mode == 2) begin
      #1;
      chk("pre_reset_push", 32'(fifo_push), 32'(beat));
      rst = 1'b0;
      #1;
      chk("reset_push_drop", 32'(fifo_push), 32'h0);
      chk("reset_ack_drop", 32'(ack), 32'h0);
      #1;
      rst = 1'b1;
      model_reset();
      exp_busy = 1'b0;
      exp_gid  = 0;
      model_next(r, f, beat);
    end
    if (beat) begin
      sb.push_back('{cyc: cyc, id: m_owner, data: wdata[m_owner]});
      last_id = m_owner;
      wdata[m_owner] = WIDTH'($urandom);
    end
    last_beat = beat;
  endtask

  task automatic sn(input logic [NREQ-1:0] r, input bit f, input int mode);
    step(r, f, mode);
    @(negedge clk);
  endtask

  // Monitor: every DUT push must match the oldest expected beat
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      if (fifo_push) begin
        if (sb.size() == 0) begin
          chk("push_without_expect", 32'(fifo_push), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("push_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("push_ack", 32'(ack), 32'h1 << mon_e.id);
          chk("push_data", 32'(fifo_data), 32'(mon_e.data));
        end
      end else begin
        chk("idle_ack", 32'(ack), 32'h0);
        chk("idle_data", 32'(fifo_data), 32'h0);
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          chk("missing_push", 32'(fifo_push), 32'h1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rv;
    int              npush;
    int              pat;
    bit              drained;

    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    req1 = 1'b0; req_data1 = 8'hA5; full1 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      wdata[i] = WIDTH'($urandom);
      rem[i]   = 0;
    end
    model_reset();

    // Reset with every writer requesting, then full rotation
    step(4'hF, 1'b0, 1);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_push", 32'(fifo_push), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    sn(4'hF, 1'b0, 1);
    for (int c = 1; c <= 22; c++) begin
      sn(4'hF, 1'b0, 0);
      if (c == 1) chk("release_c1_push", 32'(fifo_push), 32'h0);
      else begin
        pat = ((c - 2) % 5 == 4) ? 0 : (1 << (((c - 2) / 5) % 4));
        chk("rr_pattern", 32'(ack), 32'(pat));
      end
    end

    // Short burst from writer 2, then 0 and 3 contend
    sn('0, 1'b0, 1); sn('0, 1'b0, 1);
    sn(4'b0100, 1'b0, 0); chk("short_c1_push", 32'(fifo_push), 32'h0);
    sn(4'b0100, 1'b0, 0); chk("short_beat1", 32'(ack), 32'h4);
    sn(4'b0100, 1'b0, 0); chk("short_beat2", 32'(ack), 32'h4);
    sn(4'b0000, 1'b0, 0); chk("short_end_busy", 32'(busy), 32'h1);
    chk("short_end_push", 32'(fifo_push), 32'h0);
    sn(4'b1001, 1'b0, 0); chk("short_idle_busy", 32'(busy), 32'h0);
    sn(4'b1001, 1'b0, 0); chk("rr_after_short", 32'(ack), 32'h8);
    chk("gid_after_short", 32'(grant_id), 32'h3);
    repeat (3) sn(4'b1001, 1'b0, 0);

    // Full stall after beat 2, held for 5 cycles
    sn('0, 1'b0, 1); sn('0, 1'b0, 1);
    npush = 0;
    for (int c = 1; c <= 12; c++) begin
      sn((c <= 10) ? 4'b0001 : 4'b0000, (c >= 4 && c <= 8), 0);
      if (fifo_push) npush++;
      chk("stall_push", 32'(fifo_push), 32'(c == 2 || c == 3 || c == 9 || c == 10));
      if (c >= 4 && c <= 8) chk("stall_busy", 32'(busy), 32'h1);
    end
    chk("stall_total_pushes", 32'(npush), 32'h4);

    // Async reset during beat 3 of writer 1 clears rr_ptr back to 0
    sn('0, 1'b0, 1); sn('0, 1'b0, 1);
    for (int c = 1; c <= 5; c++) sn(4'b0001, 1'b0, 0);
    sn(4'b0010, 1'b0, 0);
    sn(4'b0010, 1'b0, 0);
    sn(4'b0010, 1'b0, 0);
    sn(4'b0011, 1'b0, 2);
    sn(4'b0011, 1'b0, 0);
    chk("rr_after_reset", 32'(ack), 32'h1);
    chk("gid_after_reset", 32'(grant_id), 32'h0);

    // Random writers with random FIFO full
    sn('0, 1'b0, 1); sn('0, 1'b0, 1);
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = int'($urandom_range(1, 7));
        rv[i] = (rem[i] != 0);
      end
      step(rv, ($urandom_range(0, 3) == 0), 0);
      if (last_beat) rem[last_id]--;
    end
    drained = 1'b0;
    for (int t = 0; t < 1000 && !drained; t++) begin
      for (int i = 0; i < NREQ; i++) rv[i] = (rem[i] != 0);
      step(rv, ($urandom_range(0, 3) == 0), 0);
      if (last_beat) rem[last_id]--;
      drained = 1'b1;
      for (int i = 0; i < NREQ; i++) if (rem[i] != 0) drained = 1'b0;
    end
    repeat (3) sn('0, 1'b0, 0);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    // Single writer, single-beat bursts: push every other cycle
    sn('0, 1'b0, 1);
    for (int k = 0; k < 10; k++) begin
      step('0, 1'b0, 0);
      req1 = 1'b1;
      @(negedge clk);
      chk("n1_push", 32'(push1), 32'(k % 2));
      chk("n1_ack", 32'(ack1), 32'(k % 2));
      chk("n1_gid", 32'(gid1), 32'h0);
      if (k % 2 == 1) chk("n1_data", 32'(data1), 32'hA5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the single push port of a FIFO between `NREQ` writers. Each writer presents a request plus data; the arbiter grants one writer at a time for a burst of up to `MAXBURST` beats, drives the FIFO's push and data inputs, and backs off while the FIFO reports full. It sits directly in front of the FIFO, between the producers and the FIFO's `push`/`data_in`/`full` pins.

## Interface

**Parameters**
- `NREQ`, 4: number of writers; must be ≥1.
- `WIDTH`, 8: data width; matches the FIFO `WIDTH`.
- `MAXBURST`, 4: maximum beats per grant; must be ≥1.
- `IDW`, `$clog2(NREQ)` (minimum 1): width of `grant_id`.
- `CNTW`, `$clog2(MAXBURST+1)`: width of the beat counter.

**Ports**
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low. 0 resets all state immediately.
- `req`, input, `NREQ`: per-writer request.
- `req_data`, input, `NREQ*WIDTH`: writer i's data sits in bits `[i*WIDTH +: WIDTH]`.
- `ack`, output, `NREQ`: one-hot beat-accept. When bit i is 1, writer i's beat is pushed this cycle.
- `fifo_full`, input, 1: FIFO full flag.
- `fifo_push`, output, 1: FIFO push strobe.
- `fifo_data`, output, `WIDTH`: FIFO write data.
- `grant_id`, output, `IDW`: index of the current or last owner (registered).
- `busy`, output, 1: 1 while in the BURST state (registered).

## Operation

- State: `state` ∈ {IDLE, BURST}, `owner`, `rr_ptr`, `cnt`.
- **IDLE**
  - If `|req` and `!fifo_full`, pick the first i with `req[i]=1`, searching from `rr_ptr` upward modulo `NREQ`.
  - Next cycle: `owner=i`, `grant_id=i`, `cnt=0`, go to BURST.
  - Otherwise stay in IDLE.
  - No `ack` or push is ever issued in IDLE.
- **Beat**: happens when state=BURST, `req[owner]=1` and `fifo_full=0`.
  - `ack[owner]=1`, `fifo_push=1`, `fifo_data=req_data[owner]`.
  - `cnt` increments.
- **Burst end** (go to IDLE, and `rr_ptr=(owner+1) mod NREQ`) when either:
  - state=BURST and `req[owner]=0`, or
  - a beat occurs with `cnt==MAXBURST-1`.
- **Full while in BURST**: no beat, `cnt` holds, state holds. The stall is unbounded.
- **Writer handshake rules**:
  - Hold `req` and data stable until `ack`.
  - `req` may drop only in a cycle after an `ack`, or before the writer is ever granted.
  - Next-beat data may change in the cycle after `ack`.
- When no beat occurs, `ack=0`, `fifo_push=0` and `fifo_data=0`.
- **Fairness**: a writer that holds `req` is granted within `NREQ-1` other bursts.
- **NREQ=1**: `rr_ptr` stays 0. The only writer is re-granted after each IDLE cycle.

## Timing

- **Reset values**: state=IDLE, `rr_ptr=0`, `owner=0`, `cnt=0`, `grant_id=0`, `busy=0`.
  - All outputs read 0 while `rst=0`.
  - Mid-burst reset drops `ack` and `fifo_push` combinationally in the same cycle; the in-flight beat is lost.
- **Outputs**:
  - `ack`, `fifo_push` and `fifo_data` are combinational from registered state, `req`, `req_data` and `fifo_full`; they have zero cycles of latency from `fifo_full` deassertion.
  - `busy` and `grant_id` are registered.
- **Latency**: a request arriving in IDLE gets its first `ack` 1 cycle later. The arbitration cycle is the only overhead.
- **Throughput**: a full burst is `MAXBURST` beats in `MAXBURST` consecutive cycles with no full stalls. Each burst is followed by exactly 1 IDLE bubble cycle.
- The beat counter never reaches `MAXBURST`, so there is no overflow. `rr_ptr` wraps from `NREQ-1` to 0.

## Test plan

- **Reset**: `rst=0` with `req=4'b1111` → `ack=0`, `fifo_push=0`, `busy=0`, `grant_id=0`. Release reset → first `ack` on `ack[0]` at cycle 2 after release.
- **Round-robin, capped bursts**: NREQ=4, MAXBURST=4, all `req` held high, never full → grant order 0,1,2,3,0; each burst is 4 consecutive `ack`s followed by 1 bubble (20 cycles per rotation). FIFO receives writer data in that order.
- **Short burst**: writer 2 alone pushes 2 beats then drops `req` → 2 pushes, `busy` falls, `rr_ptr=3`. Next simultaneous request from writers 0 and 3 → 3 wins.
- **Full stall**: `fifo_full` rises mid-burst after beat 2 and is held for 5 cycles → no `ack`/push for 5 cycles, `cnt` holds, `busy=1`. After `fifo_full` falls → remaining 2 beats, then IDLE. Total pushes = 4.
- **Async reset mid-burst**: `rst` pulsed low between clock edges during beat 3 → `fifo_push` drops immediately, state returns to IDLE, `rr_ptr=0`.
- **Wrap and single writer**: NREQ=1, MAXBURST=1, `req` held → push pattern 1,0,1,0…, `grant_id` stays 0.
